// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: write-size encoding and
// the owner tag that routes each one-cycle-late read response.
package mem_pkg;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    // Wide enough for the largest allowed starvation limit (15).
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        INSTR   = 2'd1,
        DATA_RD = 2'd2,
        DATA_WR = 2'd3
    } owner_t;

    // Tag for the request granted this cycle; NONE when nothing was granted.
    function automatic owner_t grant_owner(input logic gnt_i, input logic gnt_d,
                                           input logic [1:0] wr);
        owner_t o;
        o = NONE;
        if (gnt_i)
            o = INSTR;
        else if (gnt_d)
            o = (wr != WR_NONE) ? DATA_WR : DATA_RD;
        return o;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive refused instruction-fetch cycles; at_limit
// tells the arbiter to hand the next grant to the instruction port.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count never passes LIM.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q < LIM))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_limit_o = (cnt_q >= LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory:
// data first, with a starvation guard for fetches; responses follow by one cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_resp_valid,
    output logic [31:0]           i_resp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [1:0]            d_req_wr,
    input  logic [31:0]           d_req_wdata,
    output logic                  d_resp_valid,
    output logic [31:0]           d_resp_data,

    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [31:0]           mem_rd_data,
    output logic [1:0]            mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [31:0]           mem_wr_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic   at_limit;
    logic   gnt_i, gnt_d;
    logic   starve_inc, starve_clr;
    owner_t owner_q, owner_d;

    // Data wins a conflict unless the fetch port has waited its full quota.
    always_comb begin
        gnt_i = !rst && i_req_valid && (!d_req_valid || at_limit);
        gnt_d = !rst && d_req_valid && !gnt_i;
    end

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;

    assign starve_inc = i_req_valid && !gnt_i;
    assign starve_clr = gnt_i || !i_req_valid;

    starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_CNT_W)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (starve_inc),
        .clr_i      (starve_clr),
        .at_limit_o (at_limit)
    );

    always_comb begin
        mem_rd_addr = '0;
        mem_wr      = WR_NONE;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (gnt_i) begin
            mem_rd_addr = i_req_addr;
        end else if (gnt_d) begin
            mem_rd_addr = d_req_addr;
            mem_wr      = d_req_wr;
            if (d_req_wr != WR_NONE) begin
                mem_wr_addr = d_req_addr;
                mem_wr_data = d_req_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            owner_q <= NONE;
        else
            owner_q <= owner_d;
    end

    always_comb begin
        owner_d = grant_owner(gnt_i, gnt_d, d_req_wr);
    end

    // Gating with rst drops a response that was in flight when reset arrived.
    always_comb begin
        i_resp_valid = 1'b0;
        i_resp_data  = '0;
        d_resp_valid = 1'b0;
        d_resp_data  = '0;
        if (!rst) begin
            case (owner_q)
                INSTR: begin
                    i_resp_valid = 1'b1;
                    i_resp_data  = mem_rd_data;
                end
                DATA_RD: begin
                    d_resp_valid = 1'b1;
                    d_resp_data  = mem_rd_data;
                end
                DATA_WR: begin
                    d_resp_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and a
// rule-level reference model of grants, starvation and response routing.
module tb_mem_arbiter;

    localparam int SL = 4;

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [1:0]  wr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk, rst;
    logic        i_req_valid, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr, i_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [1:0]  d_req_wr, mem_wr;
    logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;

    mem_arbiter #(.STARVE_LIMIT(SL), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wr(d_req_wr), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .mem_wr(mem_wr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Merge a sized write into a word; sub-word data comes from the low bits of wd.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b01: r[lane*8 +: 8] = wd[7:0];
            2'b10: r[lane[1]*16 +: 16] = wd[15:0];
            2'b11: r = wd;
            default: ;
        endcase
        return r;
    endfunction

    // Environment memory: 1-cycle synchronous read, sized write at the edge.
    logic [31:0] mem [0:255];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] = pat(k);
            mem_init = 1'b1;
        end
        if (mem_wr != 2'b00)
            mem[mem_wr_addr[9:2]] = merge(mem[mem_wr_addr[9:2]], mem_wr_data, mem_wr, mem_wr_addr[1:0]);
        mem_rd_data <= mem[mem_rd_addr[9:2]];
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    bit          ref_init = 1'b0;
    int          refused  = 0;
    exp_t        ie[$], de[$];

    always @(negedge clk) begin
        logic        ei, ed;
        logic [31:0] e_rd, e_wa, e_wd;
        logic [1:0]  e_wr;
        if (!ref_init) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = pat(k);
            ref_init = 1'b1;
        end
        ei = !rst && i_req_valid && (!d_req_valid || refused == SL);
        ed = !rst && d_req_valid && !ei;
        e_rd = ei ? i_req_addr : (ed ? d_req_addr : 32'h0);
        e_wr = ed ? d_req_wr : 2'b00;
        e_wa = (ed && d_req_wr != 2'b00) ? d_req_addr : 32'h0;
        e_wd = (ed && d_req_wr != 2'b00) ? d_req_wdata : 32'h0;
        chk("i_req_ready", 32'(i_req_ready), 32'(ei));
        chk("d_req_ready", 32'(d_req_ready), 32'(ed));
        chk("mem_rd_addr", mem_rd_addr, e_rd);
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("mem_wr_addr", mem_wr_addr, e_wa);
        chk("mem_wr_data", mem_wr_data, e_wd);
        if (ei) ie.push_back('{ref_mem[i_req_addr[9:2]], cyc + 1});
        if (ed) begin
            if (d_req_wr == 2'b00) begin
                de.push_back('{ref_mem[d_req_addr[9:2]], cyc + 1});
            end else begin
                de.push_back('{32'h0, cyc + 1});
                ref_mem[d_req_addr[9:2]] = merge(ref_mem[d_req_addr[9:2]], d_req_wdata,
                                                 d_req_wr, d_req_addr[1:0]);
            end
        end
        if (rst || !i_req_valid || ei) refused = 0;
        else if (refused < SL)         refused = refused + 1;
    end

    // ---------------- monitor ----------------
    logic [31:0] i_hist[$];
    logic [31:0] last_d = 32'h0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_i_resp_valid", 32'(i_resp_valid), 32'h0);
            chk("rst_d_resp_valid", 32'(d_resp_valid), 32'h0);
            ie.delete();
            de.delete();
        end else begin
            if (i_resp_valid) begin
                if (ie.size() == 0) begin
                    chk("i_spurious_resp", 32'(i_resp_valid), 32'h0);
                end else begin
                    e = ie.pop_front();
                    chk("i_resp_data", i_resp_data, e.data);
                    chk("i_latency", 32'(cyc), 32'(e.due));
                    i_hist.push_back(i_resp_data);
                end
            end else begin
                chk("i_idle_data", i_resp_data, 32'h0);
                if (ie.size() > 0 && ie[0].due <= cyc) begin
                    chk("i_missing_resp", 32'(i_resp_valid), 32'h1);
                    void'(ie.pop_front());
                end
            end
            if (d_resp_valid) begin
                if (de.size() == 0) begin
                    chk("d_spurious_resp", 32'(d_resp_valid), 32'h0);
                end else begin
                    e = de.pop_front();
                    chk("d_resp_data", d_resp_data, e.data);
                    chk("d_latency", 32'(cyc), 32'(e.due));
                    last_d = d_resp_data;
                end
            end else begin
                chk("d_idle_data", d_resp_data, 32'h0);
                if (de.size() > 0 && de[0].due <= cyc) begin
                    chk("d_missing_resp", 32'(d_resp_valid), 32'h1);
                    void'(de.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    req_t iq[$], dq[$];

    task automatic present();
        if (iq.size() > 0) begin
            i_req_valid = iq[0].v;
            i_req_addr  = iq[0].addr;
        end else begin
            i_req_valid = 1'b0;
        end
        if (dq.size() > 0) begin
            d_req_valid = dq[0].v;
            d_req_addr  = dq[0].addr;
            d_req_wr    = dq[0].wr;
            d_req_wdata = dq[0].wdata;
        end else begin
            d_req_valid = 1'b0;
        end
    endtask

    task automatic tick();
        bit pi, pd;
        @(negedge clk);
        pi = (i_req_valid && i_req_ready) || (iq.size() > 0 && !iq[0].v);
        pd = (d_req_valid && d_req_ready) || (dq.size() > 0 && !dq[0].v);
        @(posedge clk);
        #1;
        if (pi && iq.size() > 0) void'(iq.pop_front());
        if (pd && dq.size() > 0) void'(dq.pop_front());
        present();
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(iq.size() + dq.size()), 32'h0);
        tick();
        tick();
    endtask

    function automatic req_t rd(input logic [31:0] a);
        return '{1'b1, a, 2'b00, 32'h0};
    endfunction

    function automatic req_t wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        return '{1'b1, a, s, d};
    endfunction

    localparam req_t HOLE = '{1'b0, 32'h0, 2'b00, 32'h0};

    initial begin
        rst = 1'b1;
        i_req_valid = 1'b0; i_req_addr = 32'h0;
        d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_wr = 2'b00; d_req_wdata = 32'h0;

        // Reset held two cycles with both ports requesting.
        iq.push_back(rd(32'h10));
        dq.push_back(rd(32'h20));
        present();
        tick();
        tick();
        rst = 1'b0;
        drain("reset_drain", 20);

        // Preload a short program through the data port, then fetch it.
        dq.push_back(wr(32'h0, 2'b11, 32'h00000013));
        dq.push_back(wr(32'h4, 2'b11, 32'h00500093));
        dq.push_back(wr(32'h8, 2'b11, 32'h00a00113));
        present();
        drain("preload_drain", 20);
        i_hist.delete();
        iq.push_back(rd(32'h0));
        iq.push_back(rd(32'h4));
        iq.push_back(rd(32'h8));
        present();
        drain("fetch_drain", 20);
        chk("fetch_count", 32'(i_hist.size()), 32'd3);
        if (i_hist.size() == 3) begin
            chk("fetch_word0", i_hist[0], 32'h00000013);
            chk("fetch_word1", i_hist[1], 32'h00500093);
            chk("fetch_word2", i_hist[2], 32'h00a00113);
        end

        // Continuous contention: 4 data grants then one fetch, repeating.
        for (int k = 0; k < 6; k++) iq.push_back(rd(32'($urandom_range(0, 255)) << 2));
        for (int k = 0; k < 30; k++) dq.push_back(rd(32'($urandom_range(0, 255)) << 2));
        present();
        drain("contention_drain", 100);

        // Write, read-back, byte merge.
        dq.push_back(wr(32'h100, 2'b11, 32'hDEADBEEF));
        dq.push_back(rd(32'h100));
        dq.push_back(wr(32'h101, 2'b01, 32'h000000AB));
        dq.push_back(rd(32'h100));
        present();
        drain("wr_rd_drain", 20);
        chk("byte_merge_read", last_d, 32'hDEADABEF);

        // Reset while a read response is in flight: it must be dropped.
        dq.push_back(rd(32'h104));
        dq.push_back(rd(32'h108));
        present();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drain("midreset_drain", 20);

        // Alternating single requests.
        for (int k = 0; k < 6; k++) begin
            iq.push_back(rd(32'(k) << 2));
            iq.push_back(HOLE);
            dq.push_back(HOLE);
            dq.push_back(rd(32'h200 + (32'(k) << 2)));
        end
        present();
        drain("alternate_drain", 40);

        // Random traffic with sized writes and occasional reset.
        for (int k = 0; k < 600; k++) begin
            if (iq.size() == 0 && $urandom_range(0, 3) != 0)
                iq.push_back(rd(32'($urandom_range(0, 255)) << 2));
            if (dq.size() == 0 && $urandom_range(0, 3) != 0) begin
                logic [1:0]  s;
                logic [31:0] a;
                s = 2'($urandom_range(0, 3));
                a = 32'($urandom_range(0, 1023));
                if (s == 2'b10) a[0] = 1'b0;
                if (s == 2'b11 || s == 2'b00) a[1:0] = 2'b00;
                dq.push_back(wr(a, s, $urandom));
            end
            present();
            rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        present();
        drain("random_drain", 200);
        chk("i_queue_empty", 32'(ie.size()), 32'h0);
        chk("d_queue_empty", 32'(de.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported unified memory (1-cycle synchronous read, sized write) between the core's instruction-fetch port and its data port.
- Sits between riscv_core and a single memory instance, replacing the separate instruction and data memories.
- Grants at most one request per cycle; data accesses have priority.
- A starvation guard bounds instruction-fetch wait.
- Returns each response to the requester that issued it.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles the instruction port may be refused while valid before it is forced a grant (1..15).
- ADDR_WIDTH, 32, byte-address width of all ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_valid  in  1  instruction fetch request
- i_req_ready  out  1  instruction request granted this cycle
- i_req_addr  in  ADDR_WIDTH  fetch address
- i_resp_valid  out  1  fetch data valid
- i_resp_data  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request granted this cycle
- d_req_addr  in  ADDR_WIDTH  data address
- d_req_wr  in  2  write size: 00 read, 01 byte, 10 half, 11 word
- d_req_wdata  in  32  write data
- d_resp_valid  out  1  data response valid (reads and writes)
- d_resp_data  out  32  read data; 0 for writes
- mem_rd_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  32  memory read data, valid one cycle after mem_rd_addr
- mem_wr  out  2  memory write size, same encoding as d_req_wr
- mem_wr_addr  out  ADDR_WIDTH  memory write address
- mem_wr_data  out  32  memory write data

Behaviour:
- Reset: synchronous, active-high, on rst at a clk edge. Clears owner register to NONE and starve_cnt to 0.
- Reset values: i_resp_valid=0, d_resp_valid=0, i_resp_data=0, d_resp_data=0.
- Reset mid-transaction: an in-flight response is dropped. No resp_valid in the cycle after rst.
- Handshake: a requester holds valid and payload stable until ready. A transfer occurs when valid && ready.
- Ready is combinational from the valids and starve_cnt. Both readys are 0 while rst is high.
- Responses have no backpressure; requesters must accept resp_valid.
- Arbitration, combinational each cycle:
  - Only one valid: that port is granted.
  - Both valid: data is granted, unless starve_cnt == STARVE_LIMIT, in which case instruction is granted.
  - Neither valid: no grant.
- starve_cnt update, registered:
  - Increments (saturating at STARVE_LIMIT) when i_req_valid && !i_req_ready.
  - Clears to 0 on an instruction grant or when i_req_valid=0.
- Memory drive, combinational:
  - mem_rd_addr = granted address, 0 if no grant.
  - mem_wr = d_req_wr only on a data grant, else 00.
  - mem_wr_addr / mem_wr_data = d_req_addr / d_req_wdata on a data write grant, else 0.
- Owner register: set on each clock to INSTR, DATA_RD, DATA_WR or NONE according to that cycle's grant.
- Responses, one cycle after grant:
  - INSTR: i_resp_valid=1, i_resp_data=mem_rd_data.
  - DATA_RD: d_resp_valid=1, d_resp_data=mem_rd_data.
  - DATA_WR: d_resp_valid=1, d_resp_data=0.
  - Response outputs are 0 whenever their valid is 0.
- Latency: fixed 1 cycle from grant to response.
- Throughput: one grant per cycle, with back-to-back grants to either or alternating ports.
- Read-after-write to the same address in consecutive cycles returns the new data; this relies on memory write-at-edge timing and the arbiter adds no forwarding.
- The address does not wrap; it is passed through unmodified.

Decomposition:
- Package mem_pkg:
  - Write-size constants WR_NONE, WR_BYTE, WR_HALF, WR_WORD.
  - owner_t enum {NONE, INSTR, DATA_RD, DATA_WR}.
- Sub-module starve_counter: saturating counter with inc/clr inputs, a limit parameter and an at_limit output.
- Arbitration logic, owner register and muxes stay in mem_arbiter.

Test Plan:
- Reset: hold rst high 2 cycles with both valids asserted -> both readys 0, both resp_valids 0, mem_wr=00. First grant occurs in the cycle rst is low.
- Instruction-only stream: fetches at 0x0, 0x4, 0x8 in consecutive cycles with memory words 0x13, 0x00500093, 0x00a00113 -> i_req_ready high each cycle; i_resp_data returns those words one cycle after each grant.
- Contention, STARVE_LIMIT=4: both ports valid continuously -> data granted 4 cycles, instruction granted on the 5th, pattern repeats. i_resp_valid every 5th cycle; starve_cnt never exceeds 4.
- Write then read: data word write of 0xDEADBEEF to 0x100, then read 0x100 the next cycle -> mem_wr=11 for one cycle; d_resp_valid for the write with data 0; read response 0xDEADBEEF. Byte write (01) of 0xAB to 0x101 -> read of 0x100 returns 0xDEADABEF.
- Reset mid-operation: assert rst in the cycle a data read is granted -> no d_resp_valid the next cycle; owner is NONE after reset.
- Alternating single requests: i_req_valid and d_req_valid in alternate cycles -> each granted immediately, and responses route to the correct port with no cross-talk.
